// File: rtl/rf_pkg.sv
// Shared types for the register-file writeback path.
// Fixed widths and the write-request/grant encodings used by the arbiter.
package rf_pkg;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_P,
        GNT_M
    } grant_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Purpose: busy bit per register for results still owed by the multi-cycle unit.
// Latency: set/clear visible the cycle after the edge; all read ports are combinational.
// Backpressure: none; the caller gates set_en with the issue-check port.
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_rd,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_rd,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic [REG_ADDR_W-1:0] chk_rd,
    output logic                  hazard,
    output logic                  chk_busy
);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en) set_mask[set_rd] = 1'b1;
        if (clr_en) clr_mask[clr_rd] = 1'b1;
    end

    // x0 never holds a pending result, so its bit is masked on every update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            busy <= (busy | set_mask) & ~clr_mask & {{(NUM_REGS-1){1'b1}}, 1'b0};
        end
    end

    assign hazard   = busy[rs1] | busy[rs2] | busy[rd];
    assign chk_busy = busy[chk_rd];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Purpose: shares the register-file write port between pipeline writeback and the mul/div unit.
// Latency: zero-cycle grant; scoreboard and starvation counter update on the write edge.
// Backpressure: m_ready low while the pipeline wins; p_stall only when a starved result is forced.
module regfile_wb_arbiter
    import rf_pkg::*;
#(
    parameter int XLEN         = rf_pkg::XLEN,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  p_valid,
    input  logic [REG_ADDR_W-1:0] p_rd,
    input  logic [XLEN-1:0]       p_data,
    output logic                  p_stall,
    input  logic                  m_valid,
    input  logic [REG_ADDR_W-1:0] m_rd,
    input  logic [XLEN-1:0]       m_data,
    output logic                  m_ready,
    input  logic                  iss_valid,
    input  logic [REG_ADDR_W-1:0] iss_rd,
    output logic                  iss_ready,
    input  logic [REG_ADDR_W-1:0] dec_rs1,
    input  logic [REG_ADDR_W-1:0] dec_rs2,
    input  logic [REG_ADDR_W-1:0] dec_rd,
    output logic                  hazard,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_rd,
    output logic [XLEN-1:0]       rf_wdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] wait_cnt;
    logic             force_m;
    logic             m_hs;
    logic             iss_busy;
    logic             sb_set;
    grant_e           grant;
    wb_req_t          p_req;
    wb_req_t          m_req;
    wb_req_t          wr_req;

    assign p_req = '{valid: p_valid, rd: p_rd, data: p_data};
    assign m_req = '{valid: m_valid, rd: m_rd, data: m_data};

    assign force_m = m_valid && (wait_cnt == CNT_MAX);

    always_comb begin
        grant = GNT_NONE;
        if (p_req.valid && !force_m) begin
            grant = GNT_P;
        end else if (m_req.valid) begin
            grant = GNT_M;
        end
    end

    always_comb begin
        case (grant)
            GNT_P:   wr_req = p_req;
            GNT_M:   wr_req = m_req;
            default: wr_req = '0;
        endcase
    end

    assign m_ready  = (grant == GNT_M);
    assign p_stall  = force_m && p_valid;
    assign m_hs     = m_valid && m_ready;
    assign rf_we    = wr_req.valid && (wr_req.rd != '0);
    assign rf_rd    = wr_req.rd;
    assign rf_wdata = wr_req.data;

    // Counts only cycles the waiting result loses to the pipeline.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (!m_valid || m_hs) begin
            wait_cnt <= '0;
        end else if (wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign iss_ready = !iss_busy;
    assign sb_set    = iss_valid && iss_ready && (iss_rd != '0);

    rf_scoreboard u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .set_en   (sb_set),
        .set_rd   (iss_rd),
        .clr_en   (m_hs),
        .clr_rd   (m_rd),
        .rs1      (dec_rs1),
        .rs2      (dec_rs2),
        .rd       (dec_rd),
        .chk_rd   (iss_rd),
        .hazard   (hazard),
        .chk_busy (iss_busy)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic against a reference model.
module tb_regfile_wb_arbiter;

    localparam int XLEN = 64;
    localparam int L    = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            p_valid, m_valid, iss_valid;
    logic [4:0]      p_rd, m_rd, iss_rd, dec_rs1, dec_rs2, dec_rd;
    logic [XLEN-1:0] p_data, m_data;
    logic            p_stall, m_ready, iss_ready, hazard, rf_we;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_wdata;

    // reference model state and expected outputs
    logic [31:0]     mb;
    int              mw;
    logic            e_hazard, e_iss_ready, e_p_stall, e_m_ready, e_we;
    logic [4:0]      e_rd;
    logic [XLEN-1:0] e_wdata;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(L)) dut (
        .clk(clk), .reset(reset),
        .p_valid(p_valid), .p_rd(p_rd), .p_data(p_data), .p_stall(p_stall),
        .m_valid(m_valid), .m_rd(m_rd), .m_data(m_data), .m_ready(m_ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .hazard(hazard),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
    );

    function automatic void eval();
        bit frc, gp, gm;
        frc         = (mw == L) && m_valid;
        gp          = p_valid && !frc;
        e_m_ready   = gp ? 1'b0 : m_valid;
        e_p_stall   = frc && p_valid;
        gm          = m_valid && e_m_ready;
        e_hazard    = mb[dec_rs1] | mb[dec_rs2] | mb[dec_rd];
        e_iss_ready = !mb[iss_rd];
        if (gp) begin
            e_we = (p_rd != 0); e_rd = p_rd; e_wdata = p_data;
        end else if (gm) begin
            e_we = (m_rd != 0); e_rd = m_rd; e_wdata = m_data;
        end else begin
            e_we = 1'b0; e_rd = '0; e_wdata = '0;
        end
    endfunction

    // Advance the model by the coming edge, then move to just after it.
    task automatic tick();
        bit hs;
        eval();
        if (!reset) begin
            mb = '0; mw = 0;
        end else begin
            hs = m_valid && e_m_ready;
            if (iss_valid && e_iss_ready && iss_rd != 0) mb[iss_rd] = 1'b1;
            if (hs) mb[m_rd] = 1'b0;
            mb[0] = 1'b0;
            if (!m_valid || hs) mw = 0;
            else if (mw < L) mw = mw + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        p_valid = 0; p_rd = 0; p_data = 0;
        m_valid = 0; m_rd = 0; m_data = 0;
        iss_valid = 0; iss_rd = 0;
        dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
    endtask

    task automatic test_reset();
        dec_rs1 = 5; iss_rd = 5;
        #1;
        n_chk++; if (hazard !== 1'b0) $display("FAIL rst_hazard got %b want 0", hazard); else n_pass++;
        n_chk++; if (iss_ready !== 1'b1) $display("FAIL rst_iss_ready got %b want 1", iss_ready); else n_pass++;
        m_valid = 1; m_rd = 6; m_data = 64'h66;
        #1;
        n_chk++; if (m_ready !== 1'b1) $display("FAIL rst_m_ready got %b want 1", m_ready); else n_pass++;
        n_chk++; if ({rf_we, rf_rd} !== {1'b1, 5'd6}) $display("FAIL rst_m_write got we=%b rd=%0d want we=1 rd=6", rf_we, rf_rd); else n_pass++;
        p_valid = 1; p_rd = 2;
        #1;
        n_chk++; if (m_ready !== 1'b0) $display("FAIL rst_m_ready_p got %b want 0", m_ready); else n_pass++;
        n_chk++; if (p_stall !== 1'b0) $display("FAIL rst_p_stall got %b want 0", p_stall); else n_pass++;
        n_chk++; if (rf_rd !== 5'd2) $display("FAIL rst_p_write got rd=%0d want 2", rf_rd); else n_pass++;
        clear_in();
        @(posedge clk); #2;
        reset = 1;
        mb = '0; mw = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_issue_complete();
        clear_in(); iss_valid = 1; iss_rd = 5;
        #1;
        n_chk++; if (iss_ready !== 1'b1) $display("FAIL ic_issue_ready got %b want 1", iss_ready); else n_pass++;
        tick();
        clear_in(); dec_rs1 = 5; iss_rd = 5;
        #1;
        n_chk++; if (hazard !== 1'b1) $display("FAIL ic_hazard_set got %b want 1", hazard); else n_pass++;
        n_chk++; if (iss_ready !== 1'b0) $display("FAIL ic_iss_blocked got %b want 0", iss_ready); else n_pass++;
        tick();
        clear_in(); m_valid = 1; m_rd = 5; m_data = 64'hAB; dec_rs1 = 5;
        #1;
        n_chk++; if (m_ready !== 1'b1) $display("FAIL ic_m_ready got %b want 1", m_ready); else n_pass++;
        n_chk++; if ({rf_we, rf_rd, rf_wdata} !== {1'b1, 5'd5, 64'hAB})
            $display("FAIL ic_write got we=%b rd=%0d data=%h want we=1 rd=5 data=ab", rf_we, rf_rd, rf_wdata);
        else n_pass++;
        n_chk++; if (hazard !== 1'b1) $display("FAIL ic_no_bypass got %b want 1", hazard); else n_pass++;
        tick();
        clear_in(); dec_rs1 = 5;
        #1;
        n_chk++; if (hazard !== 1'b0) $display("FAIL ic_hazard_drop got %b want 0", hazard); else n_pass++;
    endtask

    task automatic test_starvation();
        clear_in(); tick();
        p_valid = 1; p_rd = 3; p_data = 64'h11;
        m_valid = 1; m_rd = 7; m_data = 64'h77;
        for (int c = 1; c <= 6; c++) begin
            #1;
            if (c == 5) begin
                n_chk++; if ({m_ready, p_stall} !== 2'b11) $display("FAIL st_force c=%0d got m_ready=%b p_stall=%b want 1 1", c, m_ready, p_stall); else n_pass++;
                n_chk++; if ({rf_rd, rf_wdata} !== {5'd7, 64'h77}) $display("FAIL st_force_wr got rd=%0d data=%h want 7 77", rf_rd, rf_wdata); else n_pass++;
            end else begin
                n_chk++; if ({m_ready, p_stall} !== 2'b00) $display("FAIL st_pipe c=%0d got m_ready=%b p_stall=%b want 0 0", c, m_ready, p_stall); else n_pass++;
                n_chk++; if ({rf_we, rf_rd, rf_wdata} !== {1'b1, 5'd3, 64'h11}) $display("FAIL st_pipe_wr c=%0d got rd=%0d data=%h want 3 11", c, rf_rd, rf_wdata); else n_pass++;
            end
            tick();
        end
        clear_in(); tick();
    endtask

    task automatic test_x0();
        clear_in(); iss_valid = 1; iss_rd = 0;
        #1;
        n_chk++; if (iss_ready !== 1'b1) $display("FAIL x0_issue_ready got %b want 1", iss_ready); else n_pass++;
        tick();
        clear_in(); m_valid = 1; m_rd = 0; m_data = 64'h55;
        #1;
        n_chk++; if (hazard !== 1'b0) $display("FAIL x0_hazard got %b want 0", hazard); else n_pass++;
        n_chk++; if ({m_ready, rf_we} !== 2'b10) $display("FAIL x0_write got m_ready=%b we=%b want 1 0", m_ready, rf_we); else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        clear_in(); iss_valid = 1; iss_rd = 9; tick();
        iss_rd = 10; tick();
        iss_rd = 11; m_valid = 1; m_rd = 9; m_data = 64'h99;
        #1;
        n_chk++; if ({iss_ready, m_ready, rf_rd} !== {2'b11, 5'd9}) $display("FAIL b2b_same_edge got iss=%b m=%b rd=%0d want 1 1 9", iss_ready, m_ready, rf_rd); else n_pass++;
        tick();
        clear_in();
        for (int r = 0; r < 32; r++) begin
            dec_rs1 = 5'(r);
            #1;
            n_chk++; if (hazard !== (r == 10 || r == 11)) $display("FAIL b2b_busy r=%0d got %b want %b", r, hazard, (r == 10 || r == 11)); else n_pass++;
        end
        clear_in(); m_valid = 1; m_rd = 10; tick();
        m_rd = 11; tick();
        clear_in(); tick();
    endtask

    task automatic test_reset_mid();
        clear_in(); iss_valid = 1; iss_rd = 4; tick();
        clear_in(); p_valid = 1; p_rd = 1; m_valid = 1; m_rd = 20;
        repeat (3) tick();
        dec_rs1 = 4; iss_rd = 4;
        #2;
        reset = 0;
        #1;
        n_chk++; if (hazard !== 1'b0) $display("FAIL rm_hazard got %b want 0", hazard); else n_pass++;
        n_chk++; if (iss_ready !== 1'b1) $display("FAIL rm_iss_ready got %b want 1", iss_ready); else n_pass++;
        n_chk++; if ({p_stall, m_ready} !== 2'b00) $display("FAIL rm_arb got p_stall=%b m_ready=%b want 0 0", p_stall, m_ready); else n_pass++;
        #1;
        reset = 1;
        mb = '0; mw = 0;
        for (int c = 1; c <= 5; c++) begin
            #1;
            n_chk++; if (m_ready !== (c == 5)) $display("FAIL rm_count c=%0d got m_ready=%b want %b", c, m_ready, (c == 5)); else n_pass++;
            tick();
        end
        clear_in(); tick();
    endtask

    task automatic test_random();
        logic [73:0] act, exp;
        int r;
        for (int i = 0; i < 400; i++) begin
            clear_in();
            p_valid = 1'($urandom % 2);
            p_rd    = 5'($urandom);
            p_data  = {$urandom, $urandom};
            r       = int'($urandom % 32);
            m_valid = (mb[r] || r == 0) ? ($urandom % 4 != 0) : 1'b0;
            m_rd    = 5'(r);
            m_data  = {$urandom, $urandom};
            iss_valid = 1'($urandom % 2);
            iss_rd    = 5'($urandom);
            if (m_valid && iss_rd == m_rd) iss_valid = 0;
            dec_rs1 = 5'($urandom); dec_rs2 = 5'($urandom); dec_rd = 5'($urandom);
            #1;
            eval();
            act = {hazard, iss_ready, p_stall, m_ready, rf_we, rf_rd, rf_wdata};
            exp = {e_hazard, e_iss_ready, e_p_stall, e_m_ready, e_we, e_rd, e_wdata};
            n_chk++;
            if (act !== exp) $display("FAIL rand cyc=%0d got %h want %h", i, act, exp);
            else n_pass++;
            tick();
        end
    endtask

    initial begin
        reset = 1;
        mb = '0; mw = 0;
        clear_in();
        #1 reset = 0;
        test_reset();
        test_issue_complete();
        test_starvation();
        test_x0();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
